// File: rtl/i2c_slave_responder.sv
// Byte-level I2C target standing in for a TMP101: ACKs its 7-bit address, returns a
// two-byte register on reads, captures bytes on writes. SCL/SDA are oversampled on clock.
//
// state     | meaning
// IDLE      | bus free or not yet addressed
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving the address ACK, then handing off to TX or RX
// RX_DATA   | shifting in a write data byte
// RX_ACK    | driving the ACK for a received byte
// TX_DATA   | presenting read data bits, MSB first
// TX_ACK    | sampling the master's ACK/NACK
// WAIT_STOP | released; ignoring the bus until START or STOP
module i2c_slave_responder #(
   parameter logic [6:0] SlaveAddress = 7'b1001001
) (
   input  logic        clock,
   input  logic        Reset,
   input  logic        SCL,
   inout  wire         SDA,
   input  logic [15:0] TxData,
   output logic [7:0]  RxData,
   output logic        RxValid,
   output logic        Selected,
   output logic        ReadOrWrite
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  scl_sync, sda_sync;
   logic [7:0]  shift;
   logic [2:0]  bit_cnt;
   logic        phase;
   logic        byte_idx;
   logic        sda_low;
   logic        sda_drive;

   logic scl, scl_d, sda, sda_d;
   logic scl_rise, scl_fall, start_cond, stop_cond, addr_match;

   // Two synchronizer stages, third stage only for edge detection; idle bus is high.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], SCL};
         sda_sync <= {sda_sync[1:0], SDA};
      end
   end

   assign scl        = scl_sync[1];
   assign scl_d      = scl_sync[2];
   assign sda        = sda_sync[1];
   assign sda_d      = sda_sync[2];
   assign scl_rise   = scl & ~scl_d;
   assign scl_fall   = ~scl & scl_d;
   assign start_cond = scl & ~sda & sda_d;
   assign stop_cond  = scl & sda & ~sda_d;
   assign addr_match = (shift[6:0] == SlaveAddress);

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start_cond)
         state_nxt = ADDR;
      else if (stop_cond)
         state_nxt = IDLE;
      else begin
         case (state)
            ADDR:     if (scl_rise && bit_cnt == 3'd7) state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
            ADDR_ACK: if (scl_fall && phase)           state_nxt = ReadOrWrite ? TX_DATA : RX_DATA;
            RX_DATA:  if (scl_rise && bit_cnt == 3'd7) state_nxt = RX_ACK;
            RX_ACK:   if (scl_fall && phase)           state_nxt = RX_DATA;
            TX_DATA:  if (scl_fall && bit_cnt == 3'd7) state_nxt = TX_ACK;
            TX_ACK: begin
               if (scl_rise && sda)             state_nxt = WAIT_STOP;
               else if (scl_fall && phase)      state_nxt = TX_DATA;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Selected  = 1'b0;
      sda_drive = 1'b0;
      case (state)
         ADDR_ACK, RX_ACK, TX_DATA: begin
            Selected  = 1'b1;
            sda_drive = sda_low;
         end
         RX_DATA, TX_ACK: Selected = 1'b1;
         default: ;
      endcase
   end

   assign SDA = sda_drive ? 1'b0 : 1'bz;

   // phase marks the second half of an ACK slot: ACK driven (ADDR/RX) or ACK seen (TX).
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         shift       <= 8'h00;
         bit_cnt     <= 3'd0;
         phase       <= 1'b0;
         byte_idx    <= 1'b0;
         sda_low     <= 1'b0;
         RxData      <= 8'h00;
         RxValid     <= 1'b0;
         ReadOrWrite <= 1'b0;
      end else begin
         RxValid <= 1'b0;
         if (start_cond || stop_cond) begin
            bit_cnt <= 3'd0;
            phase   <= 1'b0;
            sda_low <= 1'b0;
         end else begin
            case (state)
               ADDR: if (scl_rise) begin
                  shift   <= {shift[6:0], sda};
                  bit_cnt <= bit_cnt + 3'd1;
                  phase   <= 1'b0;
                  if (bit_cnt == 3'd7 && addr_match) ReadOrWrite <= sda;
               end
               ADDR_ACK: if (scl_fall) begin
                  if (!phase) begin
                     sda_low <= 1'b1;
                     phase   <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     sda_low <= 1'b0;
                     if (ReadOrWrite) begin
                        shift    <= TxData[15:8];
                        sda_low  <= ~TxData[15];
                        byte_idx <= 1'b0;
                     end
                  end
               end
               RX_DATA: if (scl_rise) begin
                  shift   <= {shift[6:0], sda};
                  bit_cnt <= bit_cnt + 3'd1;
                  phase   <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     RxData  <= {shift[6:0], sda};
                     RxValid <= 1'b1;
                  end
               end
               RX_ACK: if (scl_fall) begin
                  sda_low <= ~phase;
                  phase   <= ~phase;
               end
               TX_DATA: if (scl_fall) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  phase   <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     sda_low <= 1'b0;
                  end else begin
                     shift   <= {shift[6:0], 1'b0};
                     sda_low <= ~shift[6];
                  end
               end
               TX_ACK: begin
                  if (scl_rise) begin
                     if (!sda) begin
                        phase    <= 1'b1;
                        byte_idx <= ~byte_idx;
                     end
                  end else if (scl_fall && phase) begin
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     shift   <= byte_idx ? TxData[7:0] : TxData[15:8];
                     sda_low <= byte_idx ? ~TxData[7] : ~TxData[15];
                  end
               end
               default: sda_low <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, directed bring-up scenarios and
// randomized transactions checked against a transaction-level model of the target.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
   localparam logic [6:0] SLAVE = 7'b1001001;
   localparam int Q = 8;

   logic        clock = 1'b0;
   logic        Reset = 1'b0;
   logic        scl = 1'b1;
   logic        m_low = 1'b0;
   logic [15:0] tx_data = 16'h0000;
   wire         sda_bus;
   wire  [7:0]  rx_data;
   wire         rx_valid, selected, rw;

   assign sda_bus = m_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_slave_responder #(.SlaveAddress(SLAVE)) dut (
      .clock(clock), .Reset(Reset), .SCL(scl), .SDA(sda_bus), .TxData(tx_data),
      .RxData(rx_data), .RxValid(rx_valid), .Selected(selected), .ReadOrWrite(rw)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   logic [7:0] rx_got[$];
   logic [7:0] rx_exp[$];

   always @(negedge clock) if (rx_valid) rx_got.push_back(rx_data);

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clock_bit(input logic val, output logic smp);
      m_low = ~val; idle(Q);
      scl = 1'b1;   idle(Q);
      smp = sda_bus; idle(Q);
      scl = 1'b0;   idle(Q);
   endtask

   task automatic i2c_start;
      m_low = 1'b0; idle(Q);
      scl = 1'b1;   idle(Q);
      m_low = 1'b1; idle(Q);
      scl = 1'b0;   idle(Q);
   endtask

   task automatic i2c_stop;
      m_low = 1'b1; idle(Q);
      scl = 1'b1;   idle(Q);
      m_low = 1'b0; idle(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] seen, output logic ack);
      for (int i = 7; i >= 0; i--) clock_bit(b[i], seen[i]);
      clock_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] b);
      logic ack_line;
      for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
      clock_bit(nack, ack_line);
      chk("m_ack_line", 16'(ack_line), 16'(nack));
   endtask

   task automatic check_rx(input string tag);
      chk({tag, "_rx_cnt"}, 16'(rx_got.size()), 16'(rx_exp.size()));
      for (int i = 0; i < rx_exp.size() && i < rx_got.size(); i++)
         chk({tag, "_rx_byte"}, 16'(rx_got[i]), 16'(rx_exp[i]));
      rx_got.delete();
      rx_exp.delete();
   endtask

   task automatic read_1a80(input string tag);
      logic [7:0] seen, b;
      logic ack;
      tx_data = 16'h1A80;
      send_byte(8'h93, seen, ack);
      chk({tag, "_addr_ack"}, 16'(ack), 0);
      chk({tag, "_sel"}, 16'(selected), 1);
      chk({tag, "_rw"}, 16'(rw), 1);
      recv_byte(1'b0, b);
      chk({tag, "_b0"}, 16'(b), 16'h1A);
      chk({tag, "_sel_b1"}, 16'(selected), 1);
      recv_byte(1'b1, b);
      chk({tag, "_b1"}, 16'(b), 16'h80);
      chk({tag, "_sel_nack"}, 16'(selected), 0);
      i2c_stop;
      chk({tag, "_sel_stop"}, 16'(selected), 0);
   endtask

   initial begin
      logic [7:0] seen, b, d, addr;
      logic ack, match, is_rd, alive, nack, last_rw;
      logic [6:0] other;
      logic [15:0] tx_prev, tx_new;
      int nbytes;

      idle(4);
      chk("rst_sda_in_reset", 16'(sda_bus), 1);
      Reset = 1'b1;
      idle(4);
      chk("rst_rxdata", 16'(rx_data), 0);
      chk("rst_rxvalid", 16'(rx_valid), 0);
      chk("rst_sel", 16'(selected), 0);
      chk("rst_rw", 16'(rw), 0);
      chk("rst_sda", 16'(sda_bus), 1);

      // read 16'h1A80: ACK then NACK
      i2c_start;
      read_1a80("rd");
      check_rx("rd");

      // write C3, 05
      i2c_start;
      send_byte(8'h92, seen, ack);
      chk("wr_addr_ack", 16'(ack), 0);
      chk("wr_rw", 16'(rw), 0);
      chk("wr_sel", 16'(selected), 1);
      send_byte(8'hC3, seen, ack);
      chk("wr_ack0", 16'(ack), 0);
      send_byte(8'h05, seen, ack);
      chk("wr_ack1", 16'(ack), 0);
      i2c_stop;
      rx_exp.push_back(8'hC3);
      rx_exp.push_back(8'h05);
      check_rx("wr");
      chk("wr_rxdata", 16'(rx_data), 16'h05);

      // foreign address: bus must stay untouched
      i2c_start;
      send_byte(8'hA3, seen, ack);
      chk("mm_addr_seen", 16'(seen), 16'hA3);
      chk("mm_addr_ack", 16'(ack), 1);
      chk("mm_sel", 16'(selected), 0);
      for (int k = 0; k < 8; k++) begin
         d = 8'($urandom_range(0, 255));
         send_byte(d, seen, ack);
         chk("mm_data_seen", 16'(seen), 16'(d));
         chk("mm_data_ack", 16'(ack), 1);
         chk("mm_sel_data", 16'(selected), 0);
      end
      i2c_stop;
      check_rx("mm");

      // index wraps 1 -> 0
      tx_data = 16'hABCD;
      i2c_start;
      send_byte(8'h93, seen, ack);
      chk("wrap_addr_ack", 16'(ack), 0);
      recv_byte(1'b0, b); chk("wrap_b0", 16'(b), 16'hAB);
      recv_byte(1'b0, b); chk("wrap_b1", 16'(b), 16'hCD);
      recv_byte(1'b0, b); chk("wrap_b2", 16'(b), 16'hAB);
      recv_byte(1'b1, b); chk("wrap_b3", 16'(b), 16'hCD);
      i2c_stop;

      // repeated START after a write byte, then the read scenario
      i2c_start;
      send_byte(8'h92, seen, ack);
      chk("rs_addr_ack", 16'(ack), 0);
      send_byte(8'h5A, seen, ack);
      chk("rs_data_ack", 16'(ack), 0);
      rx_exp.push_back(8'h5A);
      i2c_start;
      read_1a80("rs_rd");
      check_rx("rs");

      // reset while the target is pulling SDA low for the address ACK
      i2c_start;
      addr = 8'h93;
      for (int i = 7; i >= 0; i--) clock_bit(addr[i], seen[i]);
      chk("ack_drive_low", 16'(sda_bus), 0);
      @(negedge clock);
      #2 Reset = 1'b0;
      #1 chk("rst_async_release", 16'(sda_bus), 1);
      idle(3);
      Reset = 1'b1;
      idle(4);
      chk("rst2_rxdata", 16'(rx_data), 0);
      chk("rst2_rxvalid", 16'(rx_valid), 0);
      chk("rst2_sel", 16'(selected), 0);
      chk("rst2_rw", 16'(rw), 0);
      chk("rst2_sda", 16'(sda_bus), 1);
      scl = 1'b1;
      idle(Q);
      rx_got.delete();

      // randomized transactions against the transaction-level model
      last_rw = 1'b0;
      for (int t = 0; t < 8; t++) begin
         match = 1'($urandom_range(0, 1));
         is_rd = 1'($urandom_range(0, 1));
         do other = 7'($urandom_range(0, 127)); while (other == SLAVE);
         addr = match ? {SLAVE, is_rd} : {other, is_rd};
         nbytes = $urandom_range(1, 4);
         tx_prev = 16'($urandom_range(0, 65535));
         tx_data = tx_prev;
         i2c_start;
         send_byte(addr, seen, ack);
         chk("rnd_addr_seen", 16'(seen), 16'(addr));
         chk("rnd_addr_ack", 16'(ack), 16'(!match));
         chk("rnd_sel", 16'(selected), 16'(match));
         if (match) last_rw = is_rd;
         chk("rnd_rw", 16'(rw), 16'(last_rw));
         if (!is_rd) begin
            for (int k = 0; k < nbytes; k++) begin
               d = 8'($urandom_range(0, 255));
               send_byte(d, seen, ack);
               chk("rnd_wr_ack", 16'(ack), 16'(!match));
               if (match) rx_exp.push_back(d);
            end
         end else begin
            alive = match;
            for (int k = 0; k < nbytes; k++) begin
               nack = (k == nbytes - 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
               tx_new = 16'($urandom_range(0, 65535));
               tx_data = tx_new;
               recv_byte(nack, b);
               if (!alive)      chk("rnd_rd_byte", 16'(b), 16'hFF);
               else if (k % 2 == 0) chk("rnd_rd_byte", 16'(b), 16'(tx_prev[15:8]));
               else             chk("rnd_rd_byte", 16'(b), 16'(tx_prev[7:0]));
               if (nack) alive = 1'b0;
               chk("rnd_rd_sel", 16'(selected), 16'(alive));
               tx_prev = tx_new;
            end
         end
         if (t == 7 || $urandom_range(0, 1) == 1) begin
            i2c_stop;
            chk("rnd_sel_stop", 16'(selected), 0);
         end
      end
      idle(8);
      check_rx("rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

Byte-level I2C target (slave) that answers the master in the I2C controller/data-unit path. It stands in for the TMP101 on the bus during bench and board bring-up. It detects START/STOP, shifts in the address byte, and ACKs its own 7-bit address. On a read it returns a two-byte register (MSB first); on a write it captures data bytes. It runs entirely on the system clock, oversampling SCL and SDA, and drives SDA open-drain only.

## Interface
Parameters:
- SlaveAddress, 7'b1001001, 7-bit address this target answers to; address byte 8'b10010011 is a read to it.

Ports:
- clock  input  1  system clock (60 MHz); every flop is on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from master; never stretched.
- SDA  inout  1  open-drain: driven 0 or released to 1'bz, never driven 1.
- TxData  input  16  read payload; byte 0 = TxData[15:8], byte 1 = TxData[7:0].
- RxData  output  8  last byte received in a write transfer.
- RxValid  output  1  one-cycle pulse when RxData updates.
- Selected  output  1  high from address ACK until STOP, repeated START or NACK.
- ReadOrWrite  output  1  R/W bit of the last matched address byte.

## Operation
- Input path: SCL and SDA pass through a 2-flop synchronizer, then a third register for edge detection.
  - SclRise/SclFall: edges of the synchronized SCL.
  - Start: synchronized SDA falls while synchronized SCL = 1.
  - Stop: synchronized SDA rises while synchronized SCL = 1.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- Start moves any state to ADDR and clears the bit counter (repeated START included). Stop moves any state to IDLE. Both take priority over same-cycle bit events.
- ADDR: shift SDA in on each SclRise, MSB first; 3-bit counter.
  - After the 8th rise, byte[7:1] == SlaveAddress → ADDR_ACK; latch ReadOrWrite = byte[0].
  - Mismatch → WAIT_STOP with SDA released.
- ADDR_ACK:
  - On the SclFall after bit 8, pull SDA low.
  - On the following SclFall (end of ACK clock), release it.
    - Read: load shift register with TxData[15:8], drive its MSB, go to TX_DATA. Byte index = 0.
    - Write: go to RX_DATA.
- TX_DATA:
  - On each SclFall, present the next bit: SDA low if bit = 0, released if bit = 1.
  - After the 8th bit's SclFall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on SclRise.
  - 0 (ACK): toggle byte index and load TxData of that byte on the next SclFall. Byte index wraps 1 → 0; TxData is resampled at each load. Continue in TX_DATA.
  - 1 (NACK): drop Selected and go to WAIT_STOP.
- RX_DATA:
  - Shift in 8 bits on SclRise.
  - On the 8th rise, update RxData and pulse RxValid for one cycle.
  - Go to RX_ACK: pull SDA low on the next SclFall, release on the following SclFall, then return to RX_DATA.
- WAIT_STOP: SDA released; only Start or Stop leave this state.
- SDA is driven low only in ADDR_ACK, RX_ACK or TX_DATA; in every other state it is released.

## Timing
- Reset values: SDA released, RxData = 8'h00, RxValid = 0, Selected = 0, ReadOrWrite = 0, state IDLE, counters 0.
- Assertion of Reset releases SDA immediately, without waiting for a clock edge, even mid-byte.
- Detection latency: a pin change produces an edge or condition pulse on the 3rd clock edge after it settles.
- SDA drive changes 1 clock after SclFall is detected, so within 4 clocks (≈67 ns) of the pin's SCL fall. This is well inside the SCL low half-period (16.7 µs at 30 kHz).
- SDA is never changed while the synchronized SCL is high, so the target cannot create a false START or STOP.
- RxValid is asserted in the clock after the 8th data SclRise is detected.
- Selected:
  - Rises in the cycle ADDR_ACK is entered.
  - Falls in the cycle Stop, Start or NACK is detected.

## Test plan
- Reset low mid-ACK with SDA pulled low → SDA goes Z without a clock edge. After Reset returns high, all outputs are at their reset values.
- START, address 8'b10010011, TxData = 16'h1A80, master ACKs byte 0 and NACKs byte 1, then STOP. Required response:
  - target ACKs the address;
  - SDA carries 8'h1A then 8'h80;
  - Selected = 1 through the 2nd byte, then 0;
  - ReadOrWrite = 1.
- START, address 8'b10010010, data 8'hC3, 8'h05, STOP. Required response:
  - ACK after each of the 3 bytes;
  - RxValid pulses twice, RxData = 8'hC3 then 8'h05;
  - ReadOrWrite = 0.
- Address 8'b10100011 (mismatch) followed by 8 more bytes → SDA stays Z throughout, Selected = 0, no RxValid.
- Read where the master ACKs 3 bytes with TxData = 16'hABCD → bytes 8'hAB, 8'hCD, 8'hAB (index wraps to 0).
- Repeated START after a write byte, then read address → write aborts with no extra RxValid, and the read proceeds as in the 8'b10010011 read scenario.
